// File: rtl/plot_receiver.sv
// rtl/plot_receiver.sv - pixel plot FIFO and full-screen clear sweep feeding one framebuffer write port
module plot_receiver #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  output logic        in_ready,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        mem_we,
  input  logic        mem_grant,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic [7:0]  drop_count,
  output logic [2:0]  fifo_level
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST = WIDTH * HEIGHT - 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]    state;
  logic [14:0]   fifo_addr [DEPTH];
  logic [2:0]    fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [2:0]    level;
  logic [14:0]   sweep;
  logic [2:0]    fill;

  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          start_clear;
  logic          sweep_last;
  logic [14:0]   push_addr;

  assign in_ready    = (state == S_IDLE) && (level < 3'(DEPTH));
  assign accept      = plot && in_ready;
  assign in_range    = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  assign push        = accept && in_range;
  assign push_addr   = 15'(32'(y) * WIDTH + 32'(x));
  assign pop         = (state == S_IDLE) && (level != 3'd0) && mem_grant;
  // A plot accepted on this edge wins over the clear request.
  assign start_clear = (state == S_IDLE) && clear_req && (level == 3'd0) && !accept;
  assign sweep_last  = (sweep == 15'(LAST));
  assign clear_busy  = (state == S_CLEAR);
  assign fifo_level  = level;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = fifo_addr[rd_ptr];
    mem_data = fifo_data[rd_ptr];
    if (state == S_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = sweep;
      mem_data = fill;
    end else begin
      mem_we   = (level != 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= colour;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count <= 8'd0;
    end else if (accept && !in_range && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      sweep      <= 15'd0;
      fill       <= 3'd0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_clear) begin
            state <= S_CLEAR;
            sweep <= 15'd0;
            fill  <= clear_colour;
          end
        end
        S_CLEAR: begin
          if (mem_grant) begin
            if (sweep_last) begin
              state      <= S_IDLE;
              sweep      <= 15'd0;
              clear_done <= 1'b1;
            end else begin
              sweep <= sweep + 15'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
